datapath_dispatcher: RTL and testbench

- Fan-out counterpart of the N-thread-to-1-datapath router: one upstream instruction stream is spread across PORTS parallel datapath lanes.
- Each lane uses the existing datapath handshake (instruction_dp/start_dp out, result_dp/finished_dp in).
- Results return upstream strictly in issue order, through a lane-index order FIFO.
- Sits between the evaluation controller and a bank of identical datapaths.

---
 rtl/datapath_dispatcher.sv | 232 +++++++++++++++++++++++
 tb/tb_datapath_dispatcher.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_dispatcher.sv
// datapath_dispatcher: spreads one upstream instruction stream over PORTS
// identical datapath lanes and returns results upstream in issue order.
// Optional per-lane watchdog enabled by the DISPATCH_TIMEOUT_EN macro
// (adds the timeout_err port).
//
// Lane FSM states:
//   state   | meaning
//   IDLE    | lane free, selectable by an accept
//   ISSUE   | start_dp pulse for one cycle
//   GUARD   | one cycle with finished_dp ignored (late-dropping datapaths)
//   WAIT    | waiting for finished_dp, result captured on it
//   DONE    | result buffered, waiting to be drained in issue order

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 16
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif

module datapath_dispatcher #(
   parameter int PORTS          = 4,
   parameter int LANE_W         = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                  clock,
   input  logic                                  resetn,
   input  logic [`INSTRUCTION_WIDTH-1:0]         in_instruction,
   input  logic                                  in_start,
   output logic                                  in_ready,
   output logic [`RESULT_WIDTH-1:0]              out_result,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [`INSTRUCTION_WIDTH*PORTS-1:0]   instruction_dp,
   output logic [PORTS-1:0]                      start_dp,
   input  logic [`RESULT_WIDTH*PORTS-1:0]        result_dp,
   input  logic [PORTS-1:0]                      finished_dp,
   output logic [PORTS-1:0]                      busy
`ifdef DISPATCH_TIMEOUT_EN
   ,
   output logic [PORTS-1:0]                      timeout_err
`endif
);

   localparam int IW    = `INSTRUCTION_WIDTH;
   localparam int RW    = `RESULT_WIDTH;
   localparam int CNT_W = $clog2(PORTS + 1);

   // Elaboration-time sanity check on the parameter set.
   if (PORTS < 1 || PORTS > 16 || (1 << LANE_W) < PORTS || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("datapath_dispatcher: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_GUARD = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } lane_state_t;

   lane_state_t             r_state     [PORTS];
   lane_state_t             w_state_nxt [PORTS];
   logic [IW-1:0]           r_instr     [PORTS];
   logic [RW-1:0]           r_buf       [PORTS];
   logic [LANE_W-1:0]       r_fifo      [PORTS];
   logic [LANE_W-1:0]       r_head;
   logic [LANE_W-1:0]       r_tail;
   logic [CNT_W-1:0]        r_count;
   logic [LANE_W-1:0]       r_rr;
   logic [RW-1:0]           r_out_result;
   logic                    r_out_valid;

   logic                    w_any_idle;
   logic                    w_found;
   logic [LANE_W-1:0]       w_cand;
   logic [LANE_W-1:0]       w_sel;
   logic                    w_accept;
   logic [LANE_W-1:0]       w_head_lane;
   logic                    w_drain;
   logic [PORTS-1:0]        w_timeout;

`ifdef DISPATCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]           r_wcnt [PORTS];
   logic [PORTS-1:0]        r_timeout_err;
   assign timeout_err = r_timeout_err;
`endif

   // Round-robin search for the first IDLE lane after the last chosen one.
   always_comb begin
      w_any_idle = 1'b0;
      w_found    = 1'b0;
      w_sel      = '0;
      w_cand     = r_rr;
      for (int k = 0; k < PORTS; k++) begin
         if (w_cand == LANE_W'(PORTS - 1)) w_cand = '0;
         else                              w_cand = w_cand + 1'b1;
         if (!w_found && r_state[w_cand] == S_IDLE) begin
            w_found = 1'b1;
            w_sel   = w_cand;
         end
      end
      for (int i = 0; i < PORTS; i++) begin
         if (r_state[i] == S_IDLE) w_any_idle = 1'b1;
      end
   end

   assign in_ready    = w_any_idle && (r_count != CNT_W'(PORTS));
   assign w_accept    = in_start && in_ready;
   assign w_head_lane = r_fifo[r_head];
   assign w_drain     = (r_count != '0) && (r_state[w_head_lane] == S_DONE)
                        && (!r_out_valid || out_ready);

   // Lane next-state logic.
   always_comb begin
      w_timeout = '0;
      for (int i = 0; i < PORTS; i++) begin
         w_state_nxt[i] = r_state[i];
         case (r_state[i])
            S_IDLE:  if (w_accept && w_sel == LANE_W'(i)) w_state_nxt[i] = S_ISSUE;
            S_ISSUE: w_state_nxt[i] = S_GUARD;
            S_GUARD: w_state_nxt[i] = S_WAIT;
            S_WAIT: begin
               if (finished_dp[i]) w_state_nxt[i] = S_DONE;
`ifdef DISPATCH_TIMEOUT_EN
               else if (r_wcnt[i] == TW'(TIMEOUT_CYCLES - 1)) begin
                  w_state_nxt[i] = S_DONE;
                  w_timeout[i]   = 1'b1;
               end
`endif
            end
            S_DONE:  if (w_drain && w_head_lane == LANE_W'(i)) w_state_nxt[i] = S_IDLE;
            default: w_state_nxt[i] = S_IDLE;
         endcase
      end
   end

   // Lane state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PORTS; i++) r_state[i] <= S_IDLE;
      end else begin
         for (int i = 0; i < PORTS; i++) r_state[i] <= w_state_nxt[i];
      end
   end

   // Per-lane instruction hold and result capture.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PORTS; i++) begin
            r_instr[i] <= '0;
            r_buf[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (r_state[i] == S_IDLE && w_accept && w_sel == LANE_W'(i))
               r_instr[i] <= in_instruction;
            if (r_state[i] == S_WAIT && finished_dp[i])
               r_buf[i] <= result_dp[i*RW +: RW];
            else if (w_timeout[i])
               r_buf[i] <= '1;
         end
      end
   end

`ifdef DISPATCH_TIMEOUT_EN
   // Watchdog counters, cleared just before WAIT; sticky error flags.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PORTS; i++) r_wcnt[i] <= '0;
         r_timeout_err <= '0;
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (r_state[i] == S_GUARD)     r_wcnt[i] <= '0;
            else if (r_state[i] == S_WAIT) r_wcnt[i] <= r_wcnt[i] + 1'b1;
         end
         r_timeout_err <= r_timeout_err | w_timeout;
      end
   end
`endif

   // Order FIFO of lane indices plus round-robin pointer.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PORTS; i++) r_fifo[i] <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_rr    <= LANE_W'(PORTS - 1);
      end else begin
         if (w_accept) begin
            r_fifo[r_tail] <= w_sel;
            r_tail         <= (r_tail == LANE_W'(PORTS - 1)) ? '0 : r_tail + 1'b1;
            r_rr           <= w_sel;
         end
         if (w_drain)
            r_head <= (r_head == LANE_W'(PORTS - 1)) ? '0 : r_head + 1'b1;
         if (w_accept && !w_drain)      r_count <= r_count + 1'b1;
         else if (!w_accept && w_drain) r_count <= r_count - 1'b1;
      end
   end

   // Upstream result register, held until consumed.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_out_result <= '0;
         r_out_valid  <= 1'b0;
      end else if (w_drain) begin
         r_out_result <= r_buf[w_head_lane];
         r_out_valid  <= 1'b1;
      end else if (r_out_valid && out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   // Output packing from registered lane state.
   always_comb begin
      instruction_dp = '0;
      start_dp       = '0;
      busy           = '0;
      for (int i = 0; i < PORTS; i++) begin
         instruction_dp[i*IW +: IW] = r_instr[i];
         start_dp[i]                = (r_state[i] == S_ISSUE);
         busy[i]                    = (r_state[i] != S_IDLE);
      end
   end

   assign out_result = r_out_result;
   assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_datapath_dispatcher.sv
// Directed bench for datapath_dispatcher with PORTS=4, 16-bit instruction
// and result. Inputs are driven and outputs sampled 1 time unit after the
// rising edge.

module tb_datapath_dispatcher;

   localparam int P = 4;

   logic            clock;
   logic            resetn;
   logic [15:0]     in_instruction;
   logic            in_start;
   logic            in_ready;
   logic [15:0]     out_result;
   logic            out_valid;
   logic            out_ready;
   logic [63:0]     instruction_dp;
   logic [P-1:0]    start_dp;
   logic [63:0]     result_dp;
   logic [P-1:0]    finished_dp;
   logic [P-1:0]    busy;
`ifdef DISPATCH_TIMEOUT_EN
   logic [P-1:0]    timeout_err;
`endif

   int checks   = 0;
   int failures = 0;

   datapath_dispatcher #(.PORTS(P), .LANE_W(2), .TIMEOUT_CYCLES(1024)) dut (
      .clock          (clock),
      .resetn         (resetn),
      .in_instruction (in_instruction),
      .in_start       (in_start),
      .in_ready       (in_ready),
      .out_result     (out_result),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .instruction_dp (instruction_dp),
      .start_dp       (start_dp),
      .result_dp      (result_dp),
      .finished_dp    (finished_dp),
      .busy           (busy)
`ifdef DISPATCH_TIMEOUT_EN
      ,
      .timeout_err    (timeout_err)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] instr;
      logic [15:0] res;
      int          lat;
      int          lane;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{instr: 16'h0005, res: 16'h00AA, lat: 3, lane: 0};
      vecs[1] = '{instr: 16'h1234, res: 16'hBEEF, lat: 0, lane: 1};
      vecs[2] = '{instr: 16'hFFFF, res: 16'h0001, lat: 1, lane: 2};
      vecs[3] = '{instr: 16'h0000, res: 16'h5A5A, lat: 5, lane: 3};
      vecs[4] = '{instr: 16'hCAFE, res: 16'h8000, lat: 2, lane: 0};

      resetn         = 1'b0;
      in_instruction = '0;
      in_start       = 1'b0;
      out_ready      = 1'b1;
      result_dp      = '0;
      finished_dp    = '0;
      #22;
      chk("rst_busy",      busy,           '0);
      chk("rst_start_dp",  start_dp,       '0);
      chk("rst_instr_dp",  instruction_dp, '0);
      chk("rst_out_valid", out_valid,      '0);
      chk("rst_out_result", out_result,    '0);
      chk("rst_in_ready",  in_ready,       1);
      resetn = 1'b1;
      tick();

      // Single transactions, one at a time; lanes rotate from lane 0.
      for (int v = 0; v < 5; v++) begin
         in_instruction = vecs[v].instr;
         in_start       = 1'b1;
         chk("vec_in_ready", in_ready, 1);
         tick();
         in_start = 1'b0;
         chk("vec_start_dp", start_dp, 64'(1 << vecs[v].lane));
         chk("vec_instr_dp", instruction_dp[vecs[v].lane*16 +: 16], vecs[v].instr);
         chk("vec_busy", busy, 64'(1 << vecs[v].lane));
         tick();
         chk("vec_start_one_cycle", start_dp, '0);
         tick();
         for (int j = 0; j < vecs[v].lat; j++) tick();
         result_dp = '0;
         result_dp[vecs[v].lane*16 +: 16] = vecs[v].res;
         finished_dp[vecs[v].lane] = 1'b1;
         tick();
         finished_dp = '0;
         chk("vec_valid_early", out_valid, 0);
         tick();
         chk("vec_out_valid", out_valid, 1);
         chk("vec_out_result", out_result, vecs[v].res);
         tick();
         chk("vec_valid_clear", out_valid, 0);
         chk("vec_busy_clear", busy, '0);
      end

      // Four back-to-back accepts, fifth rejected.
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      tick();
      in_start       = 1'b1;
      in_instruction = 16'h0100;
      for (int k = 0; k < 4; k++) begin
         chk("b2b_in_ready", in_ready, 1);
         tick();
         chk("b2b_start_dp", start_dp, 64'(1 << k));
         in_instruction = 16'(16'h0101 + k);
      end
      chk("b2b_full_ready", in_ready, 0);
      tick();
      in_start = 1'b0;
      chk("b2b_fifth_ignored", start_dp, '0);
      chk("b2b_busy", busy, 4'b1111);
      chk("b2b_instr_dp", instruction_dp, {16'h0103, 16'h0102, 16'h0101, 16'h0100});
      tick();

      // Reverse completion order; results must come out in issue order.
      result_dp = {16'h0030, 16'h0020, 16'h0010, 16'h0000};
      finished_dp = 4'b1000;
      tick();
      finished_dp = 4'b0100;
      tick();
      finished_dp = 4'b0010;
      tick();
      finished_dp = 4'b0000;
      chk("ooo_no_early_valid", out_valid, 0);
      out_ready   = 1'b0;
      finished_dp = 4'b0001;
      tick();
      finished_dp = '0;
      chk("ooo_head_done_not_out", out_valid, 0);
      tick();
      chk("ooo_first_valid", out_valid, 1);
      chk("ooo_first_result", out_result, 16'h0000);
      for (int h = 0; h < 5; h++) begin
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_result", out_result, 16'h0000);
         chk("hold_busy", busy, 4'b1110);
      end
      out_ready = 1'b1;
      tick();
      chk("bb_result1", out_result, 16'h0010);
      chk("bb_valid1", out_valid, 1);
      tick();
      chk("bb_result2", out_result, 16'h0020);
      tick();
      chk("bb_result3", out_result, 16'h0030);
      chk("bb_valid3", out_valid, 1);
      tick();
      chk("bb_drained_valid", out_valid, 0);
      chk("bb_drained_busy", busy, '0);

      // finished_dp high during ISSUE/GUARD must be ignored; rr was 3 -> lane 0.
      in_instruction = 16'h0777;
      in_start       = 1'b1;
      tick();
      in_start    = 1'b0;
      chk("grd_start_dp", start_dp, 4'b0001);
      result_dp   = 64'h0BAD;
      finished_dp = 4'b0001;
      tick();
      result_dp   = 64'h0600;
      tick();
      tick();
      finished_dp = '0;
      chk("grd_done_no_valid", out_valid, 0);
      tick();
      chk("grd_valid", out_valid, 1);
      chk("grd_result", out_result, 16'h0600);
      tick();

      // Reset in the middle of WAIT discards the work; rr restarts at lane 0.
      in_instruction = 16'h0999;
      in_start       = 1'b1;
      tick();
      in_start = 1'b0;
      chk("rw_start_lane1", start_dp, 4'b0010);
      tick();
      tick();
      tick();
      resetn = 1'b0;
      #1;
      chk("rw_busy", busy, '0);
      chk("rw_instr_dp", instruction_dp, '0);
      chk("rw_out_result", out_result, '0);
      chk("rw_out_valid", out_valid, 0);
      chk("rw_start_dp", start_dp, '0);
      resetn = 1'b1;
      tick();
      in_start = 1'b1;
      tick();
      in_start = 1'b0;
      chk("rw_rr_restart", start_dp, 4'b0001);
      finished_dp = 4'b0001;
      for (int w = 0; w < 4; w++) tick();
      finished_dp = '0;
      chk("rw_after_valid", out_valid, 1);
      chk("rw_after_result", out_result, 16'h0600);
      tick();
      tick();
      chk("rw_no_stale_response", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
